// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for N channels sharing one WIDTH-bit tri-state bus.
// Each tenure is capped at MAX_HOLD cycles, and the bus is left at high-Z for one cycle between owners.
module tri_bus_arbiter #(
    parameter int WIDTH    = 8,
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    localparam int OW      = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] din,
    output logic [N-1:0]       grant,
    output logic [OW-1:0]      owner,
    output logic               bus_oe,
    output logic [WIDTH-1:0]   bus
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_DRIVE = 2'b01;
    localparam logic [1:0] S_TURN  = 2'b10;

    logic [1:0]       r_state;
    logic [N-1:0]     r_grant;
    logic [OW-1:0]    r_owner;
    logic [OW-1:0]    r_rr;
    logic [HW-1:0]    r_hold;
    logic             r_oe;

    logic             w_found;
    logic [OW-1:0]    w_winner;
    logic [OW-1:0]    w_cand;
    int unsigned      w_idx;
    logic [N-1:0]     w_onehot;
    logic [WIDTH-1:0] w_sel;
    logic             w_release;

    // Search starts one past the last winner, so the previous owner ranks last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        w_idx    = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            w_idx  = (32'(r_rr) + i) % N;
            w_cand = OW'(w_idx);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_onehot  = N'(1) << w_winner;
    assign w_release = !req[r_owner] || (r_hold == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_oe    <= 1'b0;
            r_owner <= '0;
            r_hold  <= '0;
            r_rr    <= OW'(N - 1);
        end else begin
            case (r_state)
                S_IDLE, S_TURN: begin
                    r_hold <= '0;
                    if (w_found) begin
                        r_state <= S_DRIVE;
                        r_grant <= w_onehot;
                        r_oe    <= 1'b1;
                        r_owner <= w_winner;
                        r_rr    <= w_winner;
                    end else begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_oe    <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (w_release) begin
                        r_state <= S_TURN;
                        r_grant <= '0;
                        r_oe    <= 1'b0;
                        r_hold  <= '0;
                    end else begin
                        r_hold  <= r_hold + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_oe    <= 1'b0;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_owner == OW'(i)) w_sel = din[i*WIDTH +: WIDTH];
        end
    end

    assign grant  = r_grant;
    assign owner  = r_owner;
    assign bus_oe = r_oe;
    assign bus    = r_oe ? w_sel : 'z;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed tests for tri_bus_arbiter, followed by a randomized run that checks the bus invariants.
module tb_tri_bus_arbiter;

    localparam int WIDTH    = 8;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*WIDTH-1:0] din;
    logic [N-1:0]     grant;
    logic [1:0]       owner;
    logic             bus_oe;
    wire  [WIDTH-1:0] bus;

    int total = 0;
    int bad   = 0;

    tri_bus_arbiter #(.WIDTH(WIDTH), .N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .grant(grant), .owner(owner), .bus_oe(bus_oe), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
    endtask

    // Checks the driven state for a channel: its grant bit, owner index, output enable and bus data.
    task automatic chk_drive(input string tag, input int ch);
        logic [WIDTH-1:0] exp_d;
        exp_d = din[ch*WIDTH +: WIDTH];
        chk({tag, "_grant"}, 32'(grant), 32'(4'b0001 << ch));
        chk({tag, "_owner"}, 32'(owner), 32'(ch));
        chk({tag, "_oe"},    32'(bus_oe), 32'd1);
        chk({tag, "_bus"},   32'(bus), 32'(exp_d));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant0"}, 32'(grant), 32'd0);
        chk({tag, "_oe0"},    32'(bus_oe), 32'd0);
    endtask

    logic [N-1:0] prev_grant;
    int           run;
    logic [WIDTH-1:0] exp_bus;

    initial begin
        rst = 1'b1;
        req = '0;
        din = 32'h44_33_22_11;

        // Reset values.
        step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_oe",    32'(bus_oe), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        rst = 1'b0;

        // 1: single requester, one-cycle grant latency, din pass-through, release.
        req = 4'b0001;
        step();
        chk_drive("t1_c1", 0);
        din[7:0] = 8'hA5;
        #1;
        chk("t1_passthru", 32'(bus), 32'h0000_00A5);
        step();
        chk_drive("t1_c2", 0);
        step();
        chk_drive("t1_c3", 0);
        req = 4'b0000;
        step();
        chk_idle("t1_turn");
        step();
        chk_idle("t1_idle");
        chk("t1_owner_hold", 32'(owner), 32'd0);

        // 2: all requesting; round-robin 0,1,2,3,0 with 4 DRIVE + 1 TURN each.
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                step();
                chk_drive($sformatf("t2_g%0d_c%0d", g, c), g % N);
            end
            step();
            chk_idle($sformatf("t2_turn%0d", g));
        end

        // 3: lone continuous requester on channel 2.
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("t3_grant%0d", i), 32'(grant), (i % 5 == 4) ? 32'd0 : 32'h4);
            chk($sformatf("t3_owner%0d", i), 32'(owner), 32'd2);
        end

        // 4: ch3 waits behind ch1 without pre-empting; handover takes two edges.
        do_reset();
        req = 4'b0010;
        step();
        chk_drive("t4_own1", 1);
        req = 4'b1010;
        step();
        chk_drive("t4_nopreempt", 1);
        req = 4'b1000;
        step();
        chk_idle("t4_turn");
        chk("t4_owner_turn", 32'(owner), 32'd1);
        step();
        chk_drive("t4_own3", 3);

        // 5: reset in mid-DRIVE, after which channel 0 has first priority again.
        do_reset();
        req = 4'b0100;
        step();
        chk_drive("t5_own2", 2);
        step();
        rst = 1'b1;
        req = 4'b1111;
        step();
        chk_idle("t5_rst");
        chk("t5_rst_owner", 32'(owner), 32'd0);
        rst = 1'b0;
        step();
        chk_drive("t5_first", 0);

        // 6: random req/din with invariant checks.
        do_reset();
        prev_grant = '0;
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            req = 4'($urandom_range(0, 15));
            din = $urandom;
            step();
            chk("r_onehot0", 32'($onehot0(grant)), 32'd1);
            chk("r_oe", 32'(bus_oe), 32'(|grant));
            if (prev_grant != '0 && grant != '0)
                chk("r_noturn", 32'(grant), 32'(prev_grant));
            run = (grant == '0) ? 0 : run + 1;
            chk("r_maxhold", 32'(run <= MAX_HOLD), 32'd1);
            if (bus_oe) begin
                exp_bus = din[owner*WIDTH +: WIDTH];
                chk("r_bus", 32'(bus), 32'(exp_bus));
            end
            prev_grant = grant;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
